// File: rtl/voice_allocator_pkg.sv
// Shared types and constants for the voice allocator: FSM state encoding,
// note-on target classes (lower code wins) and default sizing.
package voice_alloc_pkg;

  localparam int DEF_NUM_VOICES = 4;
  localparam int DEF_NOTE_BITS  = 7;
  localparam int RANK_W         = $clog2(DEF_NUM_VOICES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_GAP   = 2'd2,
    ST_APPLY = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CLS_RETRIG    = 2'd0,
    CLS_FREE      = 2'd1,
    CLS_RELEASING = 2'd2,
    CLS_STEAL     = 2'd3
  } cls_e;

endpackage

// File: rtl/voice_allocator_if.sv
// Note-event handshake plus per-voice gate/note/idle bus.
// ev_valid/ev_ready: an event transfers on a clock edge where both are 1; the
// source must hold ev_on/ev_note stable while ev_valid is 1 and ev_ready is 0.
interface voice_alloc_if #(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_BITS  = 7
);
  logic                            ev_valid;
  logic                            ev_ready;
  logic                            ev_on;
  logic [NOTE_BITS-1:0]            ev_note;
  logic [NUM_VOICES-1:0]           voice_idle;
  logic [NUM_VOICES-1:0]           note_en;
  logic [NUM_VOICES*NOTE_BITS-1:0] voice_note;
  logic                            steal;

  modport master (
    output ev_valid, ev_on, ev_note, voice_idle,
    input  ev_ready, note_en, voice_note, steal
  );

  modport slave (
    input  ev_valid, ev_on, ev_note, voice_idle,
    output ev_ready, note_en, voice_note, steal
  );
endinterface

// File: rtl/voice_allocator_lru.sv
// Least-recently-assigned ranking: rank 0 is newest, NUM_VOICES-1 is oldest.
// A touch promotes the target to 0 and ages every voice that was newer than it.
module lru_rank #(
  parameter int NUM_VOICES = 4,
  parameter int RW         = $clog2(NUM_VOICES)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            touch_i,
  input  logic [RW-1:0]                   idx_i,
  output logic [NUM_VOICES-1:0][RW-1:0]   rank_o
);

  logic [NUM_VOICES-1:0][RW-1:0] rank_q, rank_d;

  always_comb begin
    rank_d = rank_q;
    if (touch_i) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (RW'(v) == idx_i) rank_d[v] = '0;
        else if (rank_q[v] < rank_q[idx_i]) rank_d[v] = rank_q[v] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < NUM_VOICES; v++) rank_q[v] <= RW'(v);
    end else begin
      rank_q <= rank_d;
    end
  end

  assign rank_o = rank_q;

endmodule

// File: rtl/voice_allocator.sv
// Voice allocator: scans one voice per cycle to pick a note-on/note-off target,
// optionally inserts a one-cycle gate gap for retrigger/steal, then applies.
module voice_allocator
  import voice_alloc_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int NOTE_BITS  = DEF_NOTE_BITS
) (
  input  logic                                          clk,
  input  logic                                          rst,
  voice_alloc_if.slave                                  bus,
  output state_e                                        state_o,
  output logic [NUM_VOICES-1:0][$clog2(NUM_VOICES)-1:0] rank_o
);

  localparam int RW = $clog2(NUM_VOICES);
  localparam logic [RW-1:0] LAST = RW'(NUM_VOICES - 1);

  state_e                              state_q, state_d;
  logic [RW-1:0]                       scan_q, scan_d;
  logic                                on_q, on_d;
  logic [NOTE_BITS-1:0]                note_q, note_d;
  logic                                bv_q, bv_d;
  cls_e                                bc_q, bc_d;
  logic [RW-1:0]                       bi_q, bi_d;
  logic [RW-1:0]                       br_q, br_d;
  logic [NUM_VOICES-1:0]               note_en_q, note_en_d;
  logic [NUM_VOICES-1:0][NOTE_BITS-1:0] vnote_q, vnote_d;
  logic                                steal_q, steal_d;
  logic                                touch;
  logic                                hit, cand_ok, better;
  cls_e                                cand_cls;
  logic [NUM_VOICES-1:0][RW-1:0]       rank;

  lru_rank #(.NUM_VOICES(NUM_VOICES), .RW(RW)) u_lru (
    .clk     (clk),
    .rst     (rst),
    .touch_i (touch),
    .idx_i   (bi_q),
    .rank_o  (rank)
  );

  always_comb begin
    state_d   = state_q;
    scan_d    = scan_q;
    on_d      = on_q;
    note_d    = note_q;
    bv_d      = bv_q;
    bc_d      = bc_q;
    bi_d      = bi_q;
    br_d      = br_q;
    note_en_d = note_en_q;
    vnote_d   = vnote_q;
    steal_d   = 1'b0;
    touch     = 1'b0;
    hit       = 1'b0;
    cand_ok   = 1'b0;
    better    = 1'b0;
    cand_cls  = CLS_STEAL;
    case (state_q)
      ST_IDLE: begin
        if (bus.ev_valid) begin
          on_d    = bus.ev_on;
          note_d  = bus.ev_note;
          scan_d  = '0;
          bv_d    = 1'b0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        hit = note_en_q[scan_q] && (vnote_q[scan_q] == note_q);
        if (on_q) begin
          cand_ok = 1'b1;
          if (hit)                    cand_cls = CLS_RETRIG;
          else if (note_en_q[scan_q]) cand_cls = CLS_STEAL;
          else if (bus.voice_idle[scan_q]) cand_cls = CLS_FREE;
          else                        cand_cls = CLS_RELEASING;
        end else begin
          // Note-off only considers held voices with the same note.
          cand_ok  = hit;
          cand_cls = CLS_RETRIG;
        end
        better = cand_ok && (!bv_q || (cand_cls < bc_q) ||
                 ((cand_cls == bc_q) && (cand_cls >= CLS_RELEASING) && (rank[scan_q] > br_q)));
        if (better) begin
          bv_d = 1'b1;
          bc_d = cand_cls;
          bi_d = scan_q;
          br_d = rank[scan_q];
        end
        scan_d = scan_q + 1'b1;
        if (scan_q == LAST) begin
          if (on_q && bv_d && ((bc_d == CLS_RETRIG) || (bc_d == CLS_STEAL))) state_d = ST_GAP;
          else state_d = ST_APPLY;
        end
      end
      ST_GAP: begin
        note_en_d[bi_q] = 1'b0;
        steal_d         = (bc_q == CLS_STEAL);
        state_d         = ST_APPLY;
      end
      ST_APPLY: begin
        if (bv_q) begin
          if (on_q) begin
            note_en_d[bi_q] = 1'b1;
            vnote_d[bi_q]   = note_q;
            touch           = 1'b1;
          end else begin
            note_en_d[bi_q] = 1'b0;
          end
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      scan_q    <= '0;
      on_q      <= 1'b0;
      note_q    <= '0;
      bv_q      <= 1'b0;
      bc_q      <= CLS_RETRIG;
      bi_q      <= '0;
      br_q      <= '0;
      note_en_q <= '0;
      vnote_q   <= '0;
      steal_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      scan_q    <= scan_d;
      on_q      <= on_d;
      note_q    <= note_d;
      bv_q      <= bv_d;
      bc_q      <= bc_d;
      bi_q      <= bi_d;
      br_q      <= br_d;
      note_en_q <= note_en_d;
      vnote_q   <= vnote_d;
      steal_q   <= steal_d;
    end
  end

  // Gated by rst so the source never sees ready while reset is held.
  assign bus.ev_ready   = (state_q == ST_IDLE) && !rst;
  assign bus.note_en    = note_en_q;
  assign bus.voice_note = vnote_q;
  assign bus.steal      = steal_q;
  assign state_o        = state_q;
  assign rank_o         = rank;

endmodule
